// File: rtl/expr_str_gen.sv
`default_nettype none
// ============================================================================
//  Module   : expr_str_gen
//  Purpose  : Buffers {digit, operator} terms from a producer in a small FIFO
//             and serialises them as an ASCII expression stream ("1+2*3"),
//             one character per accepted out_valid/out_ready handshake.
//             The stream always alternates digit/operator, so every
//             END-terminated sequence forms a valid expression.
//  Config   : STRGEN_SUB_EN - when defined, op code 2'b11 is legal and emits
//             '-' (8'h2D); when undefined that op code is rejected (err).
//  Revision : 1.0 - initial release
// ============================================================================
module expr_str_gen #(
    parameter int DEPTH = 4,    // term FIFO entries, power of 2, >= 2
    parameter int CW    = 3     // count width, 2**CW > DEPTH
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic [3:0]    push_digit,
    input  logic [1:0]    push_op,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_char,
    output logic          out_last,
    output logic          err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] c_OP_END = 2'b00;
    localparam logic [1:0] c_OP_ADD = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;
`ifdef STRGEN_SUB_EN
    localparam logic [1:0] c_OP_SUB = 2'b11;
`endif

    localparam logic [7:0] c_ASCII_ZERO = 8'h30;
    localparam logic [7:0] c_ASCII_ADD  = 8'h2B;
    localparam logic [7:0] c_ASCII_MUL  = 8'h2A;
`ifdef STRGEN_SUB_EN
    localparam logic [7:0] c_ASCII_SUB  = 8'h2D;
`endif

    // IDLE and WAIT_D behave alike; WAIT_D records that a digit is owed
    // because an operator has already gone out.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_D = 2'd1,
        S_DIGIT  = 2'd2,
        S_OP     = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Term FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [3:0]    r_mem_digit [DEPTH];
    logic [1:0]    r_mem_op    [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_err;

    // ------------------------------------------------------------------
    // Serialiser state and registered outputs
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [1:0]    r_cur_op;
    logic          r_out_valid;
    logic [7:0]    r_out_char;
    logic          r_out_last;

    logic          w_full;
    logic          w_empty;
    logic          w_digit_ok;
    logic          w_op_ok;
    logic          w_push_ok;
    logic          w_hs;
    logic          w_pop;
    logic [3:0]    w_head_digit;
    logic [1:0]    w_head_op;

    // Map an operator code to its ASCII character; END never reaches here.
    function automatic logic [7:0] f_op_ascii(input logic [1:0] op);
        logic [7:0] ch;
        ch = 8'h00;
        case (op)
            c_OP_ADD: ch = c_ASCII_ADD;
            c_OP_MUL: ch = c_ASCII_MUL;
`ifdef STRGEN_SUB_EN
            c_OP_SUB: ch = c_ASCII_SUB;
`endif
            default:  ch = 8'h00;
        endcase
        return ch;
    endfunction

    assign w_full       = (r_count == CW'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_digit_ok   = (push_digit <= 4'd9);
`ifdef STRGEN_SUB_EN
    assign w_op_ok      = 1'b1;
`else
    assign w_op_ok      = (push_op != 2'b11);
`endif
    // A full FIFO rejects the push even when a pop happens in the same cycle.
    assign w_push_ok    = push & ~w_full & w_digit_ok & w_op_ok;
    assign w_hs         = r_out_valid & out_ready;
    // Pop when waiting for a term, or straight after an operator transfers
    // so the next digit follows without a bubble.
    assign w_pop        = ~w_empty &
                          ((r_state == S_IDLE) || (r_state == S_WAIT_D) ||
                           ((r_state == S_OP) && w_hs));
    assign w_head_digit = r_mem_digit[r_rd_ptr];
    assign w_head_op    = r_mem_op[r_rd_ptr];

    // Term storage write port; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_digit[r_wr_ptr] <= push_digit;
            r_mem_op[r_wr_ptr]    <= push_op;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of 2); count tracks occupancy
    // and the sticky error flag latches any rejected push.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (push && !w_push_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    // Serialiser: emits digit then operator per term, all outputs registered.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= S_IDLE;
            r_cur_op    <= c_OP_END;
            r_out_valid <= 1'b0;
            r_out_char  <= 8'h00;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_WAIT_D: begin
                    if (w_pop) begin
                        r_state     <= S_DIGIT;
                        r_cur_op    <= w_head_op;
                        r_out_valid <= 1'b1;
                        r_out_char  <= c_ASCII_ZERO + {4'h0, w_head_digit};
                        r_out_last  <= (w_head_op == c_OP_END);
                    end
                end
                S_DIGIT: begin
                    if (out_ready) begin
                        if (r_cur_op == c_OP_END) begin
                            r_state     <= S_IDLE;
                            r_out_valid <= 1'b0;
                            r_out_char  <= 8'h00;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_state     <= S_OP;
                            r_out_char  <= f_op_ascii(r_cur_op);
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                S_OP: begin
                    if (out_ready) begin
                        if (w_pop) begin
                            r_state     <= S_DIGIT;
                            r_cur_op    <= w_head_op;
                            r_out_char  <= c_ASCII_ZERO + {4'h0, w_head_digit};
                            r_out_last  <= (w_head_op == c_OP_END);
                        end else begin
                            r_state     <= S_WAIT_D;
                            r_out_valid <= 1'b0;
                            r_out_char  <= 8'h00;
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_out_char  <= 8'h00;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign full      = w_full;
    assign count     = r_count;
    assign out_valid = r_out_valid;
    assign out_char  = r_out_char;
    assign out_last  = r_out_last;
    assign err       = r_err;

endmodule
`default_nettype wire
